// File: rtl/spad_pkg.sv
// rtl/spad_pkg.sv - shared widths and round-robin pointer helper for the scratchpad arbiter
package spad_pkg;

    localparam int SPAD_ADDR_WIDTH = 8;
    localparam int SPAD_DATA_WIDTH = 32;

    // Explicit wrap so the requester count need not be a power of two.
    function automatic int rr_next(input int ptr, input int n);
        return (ptr >= n - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/rr_arb.sv
// rtl/rr_arb.sv - combinational round-robin arbiter, search starts at ptr and wraps
module rr_arb
    import spad_pkg::*;
#(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx,
    output logic          any_gnt
);

    int            idx;
    logic [PW-1:0] idx_w;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any_gnt = 1'b0;
        idx     = 0;
        idx_w   = '0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            idx_w = PW'(idx);
            if (!any_gnt && req[idx_w]) begin
                any_gnt     = 1'b1;
                gnt[idx_w]  = 1'b1;
                gnt_idx     = idx_w;
            end
        end
    end

endmodule

// File: rtl/spad_arb.sv
// rtl/spad_arb.sv - shares one scratchpad between requesters with independent write and read round-robin grants
module spad_arb
    import spad_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = SPAD_ADDR_WIDTH,
    parameter int DATA_WIDTH = SPAD_DATA_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            resp_valid,
    output logic [DATA_WIDTH-1:0]         resp_data,
    output logic                          spad_wen,
    output logic [ADDR_WIDTH-1:0]         spad_waddr,
    output logic [DATA_WIDTH-1:0]         spad_wdata,
    output logic [ADDR_WIDTH-1:0]         spad_raddr,
    input  logic [DATA_WIDTH-1:0]         spad_rdata
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0]         wr_ptr, rd_ptr, wr_idx, rd_idx;
    logic [NUM_REQ-1:0]    wr_req, rd_req, wr_gnt, rd_gnt;
    logic                  wr_any, rd_any;
    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_arr[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_arr[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
    end

    // Requests are masked while reset is held so no grant reaches the scratchpad.
    assign wr_req = req_valid &  req_we & {NUM_REQ{rst_n}};
    assign rd_req = req_valid & ~req_we & {NUM_REQ{rst_n}};

    rr_arb #(.N(NUM_REQ), .PW(PW)) u_wr_arb (
        .req     (wr_req),
        .ptr     (wr_ptr),
        .gnt     (wr_gnt),
        .gnt_idx (wr_idx),
        .any_gnt (wr_any)
    );

    rr_arb #(.N(NUM_REQ), .PW(PW)) u_rd_arb (
        .req     (rd_req),
        .ptr     (rd_ptr),
        .gnt     (rd_gnt),
        .gnt_idx (rd_idx),
        .any_gnt (rd_any)
    );

    assign req_ready  = wr_gnt | rd_gnt;
    assign spad_wen   = wr_any;
    assign spad_waddr = wr_any ? addr_arr[wr_idx]  : '0;
    assign spad_wdata = wr_any ? wdata_arr[wr_idx] : '0;
    assign spad_raddr = rd_any ? addr_arr[rd_idx]  : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            resp_valid <= '0;
            resp_data  <= '0;
        end else begin
            if (wr_any) begin
                wr_ptr <= PW'(rr_next(int'(wr_idx), NUM_REQ));
            end
            if (rd_any) begin
                rd_ptr     <= PW'(rr_next(int'(rd_idx), NUM_REQ));
                resp_data  <= spad_rdata;
                resp_valid <= rd_gnt;
            end else begin
                resp_valid <= '0;
            end
        end
    end

endmodule

// File: tb/tb_spad_arb.sv
// tb/tb_spad_arb.sv - scoreboard bench for spad_arb with a behavioural scratchpad
module tb_spad_arb;

    localparam int N  = 2;
    localparam int AW = 8;
    localparam int DW = 32;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_we;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    resp_valid;
    logic [DW-1:0]   resp_data;
    logic            spad_wen;
    logic [AW-1:0]   spad_waddr;
    logic [DW-1:0]   spad_wdata;
    logic [AW-1:0]   spad_raddr;
    logic [DW-1:0]   spad_rdata;

    spad_arb #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .spad_wen   (spad_wen),
        .spad_waddr (spad_waddr),
        .spad_wdata (spad_wdata),
        .spad_raddr (spad_raddr),
        .spad_rdata (spad_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] mem     [256];
    logic [DW-1:0] ref_mem [256];

    assign spad_rdata = mem[spad_raddr];
    always @(posedge clk) begin
        if (spad_wen) mem[spad_waddr] <= spad_wdata;
    end

    typedef struct {
        int            who;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_bad   = 0;
    int   cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Responses are due exactly one cycle after the read was accepted.
    always @(negedge clk) begin
        exp_t       e;
        logic [1:0] oh;
        if (rst_n) begin
            if (sb.size() > 0 && sb[0].cyc == cyc - 1) begin
                e  = sb.pop_front();
                oh = '0;
                oh[e.who] = 1'b1;
                chk_eq("resp_valid", resp_valid, oh);
                chk_eq("resp_data", resp_data, e.data);
            end else if (resp_valid != '0) begin
                chk_eq("resp_unexpected", resp_valid, 0);
            end
        end
    end

    task automatic set_req(input int i, input logic v, input logic we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]          = v;
        req_we[i]             = we;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic idle();
        req_valid = '0;
        req_we    = '0;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rd(input int who, input logic [AW-1:0] a);
        exp_t e;
        e.who  = who;
        e.data = ref_mem[a];
        e.cyc  = cyc;
        sb.push_back(e);
    endtask

    logic [DW-1:0] d0, d1;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end
        rst_n     = 1'b0;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        #2;
        chk_eq("rst_resp_valid", resp_valid, 0);
        chk_eq("rst_resp_data", resp_data, 0);
        chk_eq("rst_wen", spad_wen, 0);
        chk_eq("rst_ready", req_ready, 0);
        chk_eq("rst_raddr", spad_raddr, 0);
        repeat (3) next_cyc();
        rst_n = 1'b1;

        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk_eq("idle_wen", spad_wen, 0);
            chk_eq("idle_ready", req_ready, 0);
            chk_eq("idle_resp", resp_valid, 0);
            next_cyc();
        end

        // write then read back through a different requester
        set_req(0, 1, 1, 8'h10, 32'hDEADBEEF);
        @(negedge clk);
        chk_eq("w10_ready", req_ready, 2'b01);
        chk_eq("w10_wen", spad_wen, 1);
        chk_eq("w10_waddr", spad_waddr, 8'h10);
        chk_eq("w10_wdata", spad_wdata, 32'hDEADBEEF);
        ref_mem[8'h10] = 32'hDEADBEEF;
        next_cyc();
        idle();
        set_req(1, 1, 0, 8'h10, 0);
        @(negedge clk);
        chk_eq("r10_ready", req_ready, 2'b10);
        chk_eq("r10_raddr", spad_raddr, 8'h10);
        push_rd(1, 8'h10);
        next_cyc();
        idle();
        set_req(1, 1, 1, 8'h11, 32'h11111111);
        @(negedge clk);
        chk_eq("w11_ready", req_ready, 2'b10);
        ref_mem[8'h11] = 32'h11111111;
        next_cyc();

        // continuous write contention alternates grants
        d0 = 32'h1000;
        d1 = 32'h2000;
        for (int k = 0; k < 6; k++) begin
            set_req(0, 1, 1, 8'h01, d0);
            set_req(1, 1, 1, 8'h02, d1);
            @(negedge clk);
            if (k % 2 == 0) begin
                chk_eq("alt_ready", req_ready, 2'b01);
                ref_mem[8'h01] = d0;
            end else begin
                chk_eq("alt_ready", req_ready, 2'b10);
                ref_mem[8'h02] = d1;
            end
            next_cyc();
            if (k % 2 == 0) d0 = d0 + 32'h10;
            else            d1 = d1 + 32'h10;
        end
        idle();
        set_req(0, 1, 0, 8'h01, 0);
        @(negedge clk);
        chk_eq("rd01_ready", req_ready, 2'b01);
        push_rd(0, 8'h01);
        chk_eq("final_m01", ref_mem[8'h01], 32'h1020);
        next_cyc();
        idle();
        set_req(1, 1, 0, 8'h02, 0);
        @(negedge clk);
        chk_eq("rd02_ready", req_ready, 2'b10);
        push_rd(1, 8'h02);
        chk_eq("final_m02", ref_mem[8'h02], 32'h2020);
        next_cyc();

        // same-address write and read in one cycle returns the old value
        idle();
        set_req(0, 1, 1, 8'h20, 32'h3);
        @(negedge clk);
        ref_mem[8'h20] = 32'h3;
        next_cyc();
        set_req(0, 1, 1, 8'h20, 32'h5);
        set_req(1, 1, 0, 8'h20, 0);
        @(negedge clk);
        chk_eq("wr_rd_ready", req_ready, 2'b11);
        push_rd(1, 8'h20);
        ref_mem[8'h20] = 32'h5;
        next_cyc();
        idle();
        set_req(1, 1, 0, 8'h20, 0);
        @(negedge clk);
        chk_eq("reread_ready", req_ready, 2'b10);
        push_rd(1, 8'h20);
        next_cyc();

        // concurrent read and write from different requesters
        idle();
        set_req(0, 1, 0, 8'h30, 0);
        set_req(1, 1, 1, 8'h31, 32'h77);
        @(negedge clk);
        chk_eq("dual_ready", req_ready, 2'b11);
        push_rd(0, 8'h30);
        ref_mem[8'h31] = 32'h77;
        next_cyc();
        idle();
        next_cyc();

        // reset right after a read grant discards the response
        set_req(0, 1, 0, 8'h10, 0);
        @(negedge clk);
        chk_eq("pre_rst_ready", req_ready, 2'b01);
        next_cyc();
        chk_eq("pre_rst_resp", resp_valid, 2'b01);
        rst_n = 1'b0;
        #1;
        chk_eq("mid_rst_resp", resp_valid, 0);
        chk_eq("mid_rst_data", resp_data, 0);
        set_req(0, 1, 0, 8'h01, 0);
        set_req(1, 1, 0, 8'h02, 0);
        @(negedge clk);
        chk_eq("in_rst_ready", req_ready, 0);
        chk_eq("in_rst_raddr", spad_raddr, 0);
        next_cyc();
        next_cyc();
        rst_n = 1'b1;
        @(negedge clk);
        chk_eq("post_rst_ready", req_ready, 2'b01);
        push_rd(0, 8'h01);
        next_cyc();
        idle();
        repeat (3) next_cyc();
        chk_eq("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #100000;
        chk_eq("watchdog", 1, 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/spad_arb.md
Name: spad_arb

Overview:
- Round-robin arbiter and sequencer that shares one scratchpad between NUM_REQ requesters (e.g. DMA loader, compute engine, debug port).
- The scratchpad has one write port and one asynchronous read port, so this block runs two independent arbiters: one write grant and one read grant per cycle.
- Read data is registered and returned to the granted requester one cycle after grant.
- Sits between the requesters and the scratchpad. It is the only driver of the scratchpad ports.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_WIDTH, 8, scratchpad address width; must match the scratchpad.
- DATA_WIDTH, 32, data width; must match the scratchpad.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_we  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data, same packing scheme.
- req_ready  out  NUM_REQ  request accepted this cycle (grant).
- resp_valid  out  NUM_REQ  one-hot; read data valid for requester i.
- resp_data  out  DATA_WIDTH  registered read data, shared by all requesters.
- spad_wen  out  1  to scratchpad write enable.
- spad_waddr  out  ADDR_WIDTH  to scratchpad write address.
- spad_wdata  out  DATA_WIDTH  to scratchpad write data.
- spad_raddr  out  ADDR_WIDTH  to scratchpad read address.
- spad_rdata  in  DATA_WIDTH  from scratchpad; combinational read of spad_raddr.

Behaviour:
- Reset (async, rst_n=0):
  - wr_ptr=0, rd_ptr=0.
  - resp_valid=0, resp_data=0.
  - Combinational outputs are 0 because there is no grant while reset is held: spad_wen, req_ready, spad_raddr, spad_waddr, spad_wdata.
- Classes:
  - Write-class requesters: req_valid[i] & req_we[i].
  - Read-class requesters: req_valid[i] & ~req_we[i].
  - Each class is arbitrated independently, every cycle, combinationally.
- Round-robin arbitration:
  - Search order starts at ptr: ptr, ptr+1, ..., wrapping at NUM_REQ-1 back to 0.
  - The first active requester found wins.
  - On a grant to index g, the pointer updates at the clock edge to (g+1) mod NUM_REQ.
  - With no grant, the pointer holds.
- Write grant g:
  - spad_wen=1, spad_waddr = req_addr[g], spad_wdata = req_wdata[g].
  - req_ready[g]=1. The write commits at the next clock edge.
- Read grant g:
  - spad_raddr = req_addr[g]; req_ready[g]=1.
  - At the clock edge: resp_data <= spad_rdata, resp_valid <= one-hot(g).
  - Read latency is exactly 1 cycle from accept to resp_valid.
- No read grant in a cycle: resp_valid <= 0 and resp_data holds its value. spad_raddr=0.
- Throughput: one write and one read can be accepted in the same cycle, from different requesters or from the same requester only if it somehow presents both (it cannot, since req_we is a single bit).
- Same-address write and read in the same cycle: the read returns the OLD memory contents (the write lands at the edge). There is no forwarding.
- req_ready depends combinationally on req_valid. Requesters must hold addr, wdata and we stable until ready is seen. No responses are dropped and there is no backpressure on responses: a requester must always accept resp_valid.
- Starvation bound: an active requester is granted within NUM_REQ cycles of its class.
- Reset mid-operation: an in-flight read response is discarded (resp_valid cleared) and the pointers return to 0.
- Pointer width: $clog2(NUM_REQ) with explicit wrap. NUM_REQ is not required to be a power of 2.

Decomposition:
- Package spad_pkg:
  - SPAD_ADDR_WIDTH and SPAD_DATA_WIDTH defaults.
  - Function rr_next(ptr, n) for pointer wrap.
- One sub-module rr_arb #(N): inputs req[N] and ptr; outputs one-hot gnt, gnt_idx and any_gnt.
- spad_arb instantiates rr_arb twice (write and read) and owns the pointers and the response register.

Test Plan:
- Reset, then all req_valid=0 → spad_wen=0, req_ready=0, resp_valid=0 for 10 cycles.
- Requester 0 writes addr 0x10 = 0xDEADBEEF, then requester 1 reads 0x10 → req_ready[1] in the read cycle; the next cycle has resp_valid=2'b10 and resp_data=0xDEADBEEF.
- Both requesters continuously write (addr 0x01/0x02) for 6 cycles → grants alternate 0,1,0,1,0,1; final mem[0x01] and mem[0x02] hold the last data written by each.
- Same cycle: requester 0 writes 0x20=0x5 while requester 1 reads 0x20 (previously 0x3) → resp_data=0x3; a re-read next cycle returns 0x5.
- Requester 0 reads 0x30 while requester 1 writes 0x31 in the same cycle → both req_ready bits are 1 in that single cycle.
- Assert rst_n=0 mid-cycle directly after a read grant → resp_valid drops immediately, no response appears after release, and the next contention grants requester 0 first.
